// File: rtl/arb_rr4_decoded.sv
// Four-requester round-robin arbiter with a registered winner index decoded to a
// one-hot grant, and a hold-time limit that forces rotation.
module arb_rr4_decoded #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned HOLD_W   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned IDX_W   = 2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t              state_q,     state_d;
  logic [IDX_W-1:0]    ptr_q,       ptr_d;
  logic [HOLD_W-1:0]   cnt_q,       cnt_d;
  logic [IDX_W-1:0]    gnt_idx_q,   gnt_idx_d;
  logic                gnt_valid_q, gnt_valid_d;
  logic                timeout_q,   timeout_d;
  logic [NUM_REQ-1:0]  gnt_q,       gnt_d;

  logic                rel_normal;
  logic                hold_hit;
  logic [IDX_W-1:0]    rel_ptr;

  // First set request at or after p, wrapping mod 4; p is searched first.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   p);
    logic [IDX_W-1:0] c;
    logic [IDX_W-1:0] pick;
    pick = p;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      c = p + IDX_W'(k);
      if (r[c]) pick = c;
    end
    return pick;
  endfunction

  // Release decision and next grant selection.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;

    rel_normal  = done | ~req[gnt_idx_q];
    hold_hit    = (MAX_HOLD != 0) && (cnt_q == HOLD_W'(MAX_HOLD));
    rel_ptr     = gnt_idx_q + IDX_W'(1);

    case (state_q)
      S_IDLE: begin
        if (|req) begin
          gnt_idx_d   = rr_pick(req, ptr_q);
          gnt_valid_d = 1'b1;
          cnt_d       = HOLD_W'(1);
          state_d     = S_BUSY;
        end
      end
      S_BUSY: begin
        if (rel_normal || hold_hit) begin
          // done or a dropped request takes precedence over the hold limit
          ptr_d     = rel_ptr;
          timeout_d = ~rel_normal;
          if (|req) begin
            gnt_idx_d   = rr_pick(req, rel_ptr);
            gnt_valid_d = 1'b1;
            cnt_d       = HOLD_W'(1);
          end else begin
            gnt_valid_d = 1'b0;
            cnt_d       = '0;
            state_d     = S_IDLE;
          end
        end else if (cnt_q != {HOLD_W{1'b1}}) begin
          cnt_d = cnt_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d     = S_IDLE;
        gnt_valid_d = 1'b0;
      end
    endcase

    gnt_d = gnt_valid_d ? (NUM_REQ'(1) << gnt_idx_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      gnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
      gnt_q       <= gnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_arb_rr4_decoded.sv
// Scoreboard bench for arb_rr4_decoded: a cycle-level reference model pushes the
// expected outputs per stimulus cycle; a monitor pops and compares after each edge.
module tb_arb_rr4_decoded;

  localparam int MAX_HOLD = 8;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  arb_rr4_decoded #(.MAX_HOLD(MAX_HOLD), .HOLD_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       valid;
    logic       to;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state: owner, rotation start, cycles held so far.
  int   m_valid = 0;
  int   m_owner = 0;
  int   m_ptr   = 0;
  int   m_held  = 0;
  int   m_to    = 0;

  function automatic int search(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return p;
  endfunction

  task automatic model_step(input logic r, input logic [3:0] rq, input logic d);
    int released;
    int forced;
    exp_t e;
    released = 0;
    forced   = 0;
    if (!r) begin
      m_valid = 0; m_owner = 0; m_ptr = 0; m_held = 0; m_to = 0;
    end else begin
      m_to = 0;
      if (m_valid == 0) begin
        if (rq != 4'b0000) begin
          m_owner = search(rq, m_ptr);
          m_valid = 1;
          m_held  = 1;
        end
      end else begin
        if (d || !rq[m_owner]) released = 1;
        else if (MAX_HOLD != 0 && m_held >= MAX_HOLD) begin
          released = 1;
          forced   = 1;
        end else m_held++;
        if (released != 0) begin
          m_ptr = (m_owner + 1) % 4;
          m_to  = forced;
          if (rq != 4'b0000) begin
            m_owner = search(rq, m_ptr);
            m_held  = 1;
          end else begin
            m_valid = 0;
          end
        end
      end
    end
    e.gnt   = (m_valid != 0) ? 4'(1 << m_owner) : 4'b0000;
    e.idx   = 2'(m_owner);
    e.valid = (m_valid != 0);
    e.to    = (m_to != 0);
    exp_q.push_back(e);
  endtask

  // One stimulus cycle: drive on the falling edge and log the expected response.
  task automatic cyc(input logic r, input logic [3:0] rq, input logic d);
    @(negedge clk);
    rst_n = r;
    req   = rq;
    done  = d;
    model_step(r, rq, d);
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp_v);
    end
  endtask

  // Monitor: one expected entry per clock edge once stimulus has started.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("gnt",       gnt,                e.gnt);
        check("gnt_idx",   {2'b00, gnt_idx},   {2'b00, e.idx});
        check("gnt_valid", {3'b000, gnt_valid}, {3'b000, e.valid});
        check("timeout",   {3'b000, timeout},  {3'b000, e.to});
      end
    end
  end

  initial begin
    int wait_cnt;
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;

    // Reset, then single requester with a done release.
    cyc(1'b0, 4'b0000, 1'b0);
    cyc(1'b0, 4'b0000, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 4'b0001, 1'b0);
    cyc(1'b1, 4'b0000, 1'b1);
    cyc(1'b1, 4'b0000, 1'b0);
    cyc(1'b1, 4'b0000, 1'b1);

    // All requesting, done every second grant cycle: rotation 0,1,2,3,0.
    cyc(1'b0, 4'b0000, 1'b0);
    for (int i = 0; i < 12; i++) cyc(1'b1, 4'b1111, 1'(i % 2));

    // Sole requester held past the limit: forced release and regrant.
    cyc(1'b0, 4'b0000, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b1, 4'b0100, 1'b0);

    // done coincides with the hold limit: no timeout, wrap to port 0.
    cyc(1'b0, 4'b0000, 1'b0);
    cyc(1'b1, 4'b0010, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b1, 4'b0011, 1'b0);
    cyc(1'b1, 4'b0011, 1'b1);
    cyc(1'b1, 4'b0011, 1'b0);

    // Owner 2 drops its request with port 3 pending.
    cyc(1'b0, 4'b0000, 1'b0);
    cyc(1'b1, 4'b0100, 1'b0);
    cyc(1'b1, 4'b0100, 1'b0);
    cyc(1'b1, 4'b1000, 1'b0);
    cyc(1'b1, 4'b1000, 1'b0);

    // Reset during a port-3 grant, then regrant from port 0.
    cyc(1'b1, 4'b1000, 1'b0);
    cyc(1'b0, 4'b1111, 1'b0);
    cyc(1'b1, 4'b1111, 1'b0);
    cyc(1'b1, 4'b1111, 1'b0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 99) != 0), 4'($urandom_range(0, 15)),
          ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 7) == 0) begin
        for (int j = 0; j < 12; j++) cyc(1'b1, 4'b0110, 1'b0);
      end
    end

    // Drain the scoreboard with a bounded wait.
    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 10) begin
      @(negedge clk);
      wait_cnt++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arb_rr4_decoded.md
# arb_rr4_decoded

Four-requester round-robin arbiter that shares one downstream resource among requesters 0–3. The winner is held as a registered 2-bit index and decoded with 2-to-4 decoder logic into a one-hot grant bus. A hold-time limit forces rotation so one requester cannot monopolise the resource. It sits between requester logic and the shared resource's select/enable lines.

## Interface
- MAX_HOLD, 8, maximum consecutive cycles one grant may last; 0 means unlimited.
- HOLD_W, 4, hold counter width; MAX_HOLD ≤ 2^HOLD_W − 1.
- clk  input  1  single system clock, all state on rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- req  input  4  request per requester, level-sensitive, bit i = requester i.
- done  input  1  current owner releases the resource; sampled only while a grant is valid.
- gnt  output  4  one-hot grant. Equals the decoded gnt_idx when gnt_valid=1, else 4'b0000.
- gnt_idx  output  2  index of the current or last owner.
- gnt_valid  output  1  a grant is active.
- timeout  output  1  one-cycle pulse marking a forced release.

## Operation
- State: IDLE or BUSY, rotation pointer ptr[1:0], hold counter cnt[HOLD_W-1:0]. All outputs are registered.
- Priority search: from ptr upward, mod 4, pick the first set req bit. Example: ptr=2 gives order 2,3,0,1.
- IDLE:
  - Any req set: load gnt_idx with the search winner, set gnt_valid=1, cnt=1, go to BUSY.
  - No req set: stay in IDLE.
- BUSY, release conditions in priority order:
  - done=1: normal release.
  - req[gnt_idx]=0: owner dropped its request; treated as a normal release.
  - MAX_HOLD≠0 and cnt==MAX_HOLD: forced release, timeout=1 on the next cycle.
  - Otherwise: hold the grant and increment cnt. cnt saturates and never wraps.
- On any release:
  - ptr ← gnt_idx+1 (mod 4).
  - Re-arbitrate in the same cycle using the new ptr. The old owner is searched last.
  - If a winner exists, load it next cycle with no idle bubble: gnt_valid stays 1 and cnt=1.
  - If no winner, go to IDLE with gnt_valid=0. gnt_idx keeps the last owner.
- Sole requester after a forced release: the same index is regranted with cnt reset to 1. timeout still pulses.
- done and the MAX_HOLD limit in the same cycle: done wins and timeout stays 0.
- done while IDLE: ignored.
- Requests that change between arbitrations: only their value at the arbitration edge matters.
- gnt decode: gnt[i] = gnt_valid & (gnt_idx==i). Exactly zero or one bit is set at any time.

## Timing
- Reset values: gnt=0000, gnt_idx=00, gnt_valid=0, timeout=0, ptr=00, cnt=0, state IDLE.
- Reset mid-grant: every output takes its reset value on the first edge where rst_n=0 is sampled. No release side effects occur.
- Arbitration latency is 1 cycle. A req sampled at edge k gives gnt valid after edge k.
- Release-to-regrant is 1 cycle with no gap. gnt switches directly from the old one-hot value to the new one.
- Maximum grant length is MAX_HOLD cycles. timeout is high exactly in the first cycle after the last cycle of that grant.
- Worst-case wait for a continuously requesting port is 3·MAX_HOLD cycles (with MAX_HOLD≠0).

## Test plan
- Reset, then req=0001 for 3 cycles, then done=1 for 1 cycle: gnt=0001 from cycle 1; gnt=0000 the cycle after done; ptr=1.
- After reset, req=1111 held with done pulsed every 2nd grant cycle: grant order 0,1,2,3,0, one-hot gnt 0001,0010,0100,1000,0001, no gaps.
- MAX_HOLD=8, req=0100 held, done=0: gnt=0100 for 8 cycles; timeout=1 on cycle 9 while gnt=0100 is regranted; counter restarts.
- MAX_HOLD=8, owner 1 holding with req=0011, done=1 on the same cycle cnt hits 8: timeout stays 0; next gnt=0001 (ptr=2 search wraps to 0).
- Owner 2 drops req[2] mid-grant with req=1000 pending: next cycle gnt=1000, ptr=3.
- rst_n=0 for one cycle during an active grant on port 3: next cycle all outputs are at reset values; with req=1111, the re-grant goes to port 0.
